pll_reset_sequencer: RTL and testbench

- Parametrised successor to the single-PLL wrapper; runs on the free-running PLL reference clock.
- Drives the PLL RST pin, watches PLL LOCK, and filters lock glitches.
- Releases N_CH downstream domain resets in staggered order once lock is stable.
- On lock loss it re-asserts all resets and automatically retries the PLL, with a lock-timeout, loss counter and software-forced relock.

---
 rtl/pll_reset_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Drives a PLL reset pin, watches its (asynchronous) LOCK output, filters
//   lock glitches, and releases N_CH downstream domain resets in staggered
//   order once lock is stable. Lock loss or a software relock request
//   re-asserts every domain reset and restarts the PLL. A lock timeout
//   retries the PLL reset automatically.
//
// Ports
//   CLKI         in   reference clock, sole clock of the block
//   RST          in   synchronous active-high block reset
//   LOCK         in   PLL lock, asynchronous (double-flop synchronised here)
//   FORCE_RELOCK in   single-cycle request to restart the PLL
//   PLL_RST      out  active-high reset to the PLL
//   RST_OUT      out  per-domain active-high resets, bit 0 released first
//   READY        out  all domains out of reset and lock stable
//   LOSS_CNT     out  saturating count of lock losses seen in S_RUN
//   RETRY_CNT    out  saturating count of lock-timeout retries
//   o_dbg_state  out  current FSM state (debug visibility)
module pll_reset_sequencer #(
  parameter int N_CH         = 3,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_FILTER  = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STAGGER      = 8,
  parameter int CNT_W        = 8
) (
  input  logic             CLKI,
  input  logic             RST,
  input  logic             LOCK,
  input  logic             FORCE_RELOCK,
  output logic             PLL_RST,
  output logic [N_CH-1:0]  RST_OUT,
  output logic             READY,
  output logic [CNT_W-1:0] LOSS_CNT,
  output logic [CNT_W-1:0] RETRY_CNT,
  output logic [2:0]       o_dbg_state
);

  // Timer must hold the largest terminal count of any state.
  localparam int REL_LAST = (N_CH - 1) * STAGGER;
  localparam int MAX_1    = (RST_PULSE > LOCK_FILTER) ? RST_PULSE : LOCK_FILTER;
  localparam int MAX_2    = (MAX_1 > LOCK_TIMEOUT) ? MAX_1 : LOCK_TIMEOUT;
  localparam int MAX_P    = (MAX_2 > REL_LAST) ? MAX_2 : REL_LAST;
  localparam int TW       = $clog2(MAX_P) + 1;

  localparam logic [TW-1:0] T_PULSE_END = TW'(RST_PULSE - 1);
  localparam logic [TW-1:0] T_TO_END    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_FILT_END  = TW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0] T_REL_END   = TW'(REL_LAST);

  typedef enum logic [2:0] {
    S_PLLRST  = 3'd0,
    S_WAIT    = 3'd1,
    S_FILTER  = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic            r_lock_s1;
  logic            r_lock_s2;
  logic            w_lock;
  logic            w_loss_inc;
  logic            w_retry_inc;
  logic [N_CH-1:0] w_rst_out_nxt;

  assign w_lock      = r_lock_s2;
  assign o_dbg_state = r_state;

  // Lock synchroniser
  always_ff @(posedge CLKI) begin
    if (RST) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= LOCK;
      r_lock_s2 <= r_lock_s1;
    end
  end

  // State register and shared timer
  always_ff @(posedge CLKI) begin
    if (RST) begin
      r_state <= S_PLLRST;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state logic. Lock loss takes priority over a relock request so the
  // loss counter still sees it.
  always_comb begin
    w_state_nxt = r_state;
    w_loss_inc  = 1'b0;
    w_retry_inc = 1'b0;
    case (r_state)
      S_PLLRST: begin
        // FORCE_RELOCK is deliberately ignored here.
        if (r_timer == T_PULSE_END) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (FORCE_RELOCK) begin
          w_state_nxt = S_PLLRST;
        end else if (w_lock) begin
          w_state_nxt = S_FILTER;
        end else if (r_timer == T_TO_END) begin
          w_state_nxt = S_PLLRST;
          w_retry_inc = 1'b1;
        end
      end
      S_FILTER: begin
        if (FORCE_RELOCK)              w_state_nxt = S_PLLRST;
        else if (!w_lock)              w_state_nxt = S_WAIT;
        else if (r_timer == T_FILT_END) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!w_lock || FORCE_RELOCK)   w_state_nxt = S_PLLRST;
        else if (r_timer == T_REL_END) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_lock) begin
          w_state_nxt = S_PLLRST;
          w_loss_inc  = 1'b1;
        end else if (FORCE_RELOCK) begin
          w_state_nxt = S_PLLRST;
        end
      end
      default: w_state_nxt = S_PLLRST;
    endcase
    // Timer restarts on every state change; it is not needed in S_RUN.
    if ((w_state_nxt != r_state) || (r_state == S_RUN)) w_timer_nxt = '0;
    else                                                  w_timer_nxt = r_timer + TW'(1);
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    w_rst_out_nxt = '1;
    for (int k = 0; k < N_CH; k++) begin
      if (w_state_nxt == S_RUN) begin
        w_rst_out_nxt[k] = 1'b0;
      end else if ((w_state_nxt == S_RELEASE) && (w_timer_nxt >= TW'(k * STAGGER))) begin
        w_rst_out_nxt[k] = 1'b0;
      end
    end
  end

  // Registered outputs and saturating counters
  always_ff @(posedge CLKI) begin
    if (RST) begin
      PLL_RST   <= 1'b1;
      RST_OUT   <= '1;
      READY     <= 1'b0;
      LOSS_CNT  <= '0;
      RETRY_CNT <= '0;
    end else begin
      PLL_RST <= (w_state_nxt == S_PLLRST);
      RST_OUT <= w_rst_out_nxt;
      READY   <= (w_state_nxt == S_RUN);
      if (w_loss_inc && (LOSS_CNT != '1))   LOSS_CNT  <= LOSS_CNT + CNT_W'(1);
      if (w_retry_inc && (RETRY_CNT != '1)) RETRY_CNT <= RETRY_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters:
// N_CH=3, RST_PULSE=4, LOCK_FILTER=8, STAGGER=3, LOCK_TIMEOUT=50, CNT_W=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so each tick() observes the result of exactly one edge.
module tb_pll_reset_sequencer;

  localparam int N_CH = 3;
  localparam int CNT_W = 4;

  localparam logic [31:0] ST_PLLRST  = 32'd0;
  localparam logic [31:0] ST_WAIT    = 32'd1;
  localparam logic [31:0] ST_FILTER  = 32'd2;
  localparam logic [31:0] ST_RELEASE = 32'd3;
  localparam logic [31:0] ST_RUN     = 32'd4;

  logic             clk;
  logic             rst;
  logic             lock;
  logic             force_relock;
  logic             pll_rst;
  logic [N_CH-1:0]  rst_out;
  logic             ready;
  logic [CNT_W-1:0] loss_cnt;
  logic [CNT_W-1:0] retry_cnt;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_sequencer #(
    .N_CH(N_CH), .RST_PULSE(4), .LOCK_FILTER(8), .LOCK_TIMEOUT(50),
    .STAGGER(3), .CNT_W(CNT_W)
  ) dut (
    .CLKI(clk), .RST(rst), .LOCK(lock), .FORCE_RELOCK(force_relock),
    .PLL_RST(pll_rst), .RST_OUT(rst_out), .READY(ready),
    .LOSS_CNT(loss_cnt), .RETRY_CNT(retry_cnt), .o_dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starting just after the edge that entered S_PLLRST: PLL_RST stays high
  // for three more edges, then the fourth edge moves to S_WAIT.
  task automatic pllrst_phase(input string tag);
    ticks(3);
    chk({tag, "_pllrst_hi"}, 32'(pll_rst), 32'd1);
    chk({tag, "_state_pllrst"}, 32'(dbg_state), ST_PLLRST);
    tick();
    chk({tag, "_pllrst_lo"}, 32'(pll_rst), 32'd0);
    chk({tag, "_state_wait"}, 32'(dbg_state), ST_WAIT);
  endtask

  // Starting just after the edge that entered S_WAIT with lock_s already
  // high: FILTER at +1, RST_OUT[0] drops at +9, [1] at +12, [2] at +15,
  // READY at +16.
  task automatic filter_release(input string tag);
    tick();
    chk({tag, "_state_filter"}, 32'(dbg_state), ST_FILTER);
    ticks(7);
    chk({tag, "_rst_out_w8"}, 32'(rst_out), 32'd7);
    tick();
    chk({tag, "_rst_out_w9"}, 32'(rst_out), 32'd6);
    chk({tag, "_state_release"}, 32'(dbg_state), ST_RELEASE);
    ticks(2);
    chk({tag, "_rst_out_w11"}, 32'(rst_out), 32'd6);
    tick();
    chk({tag, "_rst_out_w12"}, 32'(rst_out), 32'd4);
    ticks(2);
    chk({tag, "_rst_out_w14"}, 32'(rst_out), 32'd4);
    tick();
    chk({tag, "_rst_out_w15"}, 32'(rst_out), 32'd0);
    chk({tag, "_ready_w15"}, 32'(ready), 32'd0);
    tick();
    chk({tag, "_ready_w16"}, 32'(ready), 32'd1);
    chk({tag, "_state_run"}, 32'(dbg_state), ST_RUN);
    chk({tag, "_pll_rst_run"}, 32'(pll_rst), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_rst_out"}, 32'(rst_out), 32'd7);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), ST_PLLRST);
  endtask

  initial begin
    rst = 1'b1;
    lock = 1'b1;
    force_relock = 1'b0;
    ticks(3);
    chk_reset_values("reset");
    chk("reset_loss", 32'(loss_cnt), 32'd0);
    chk("reset_retry", 32'(retry_cnt), 32'd0);

    // Clean start with LOCK tied high
    rst = 1'b0;
    pllrst_phase("clean");
    filter_release("clean");

    // Relock request from S_RUN: back to S_PLLRST, no counter change
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk_reset_values("force_run");
    chk("force_run_loss", 32'(loss_cnt), 32'd0);
    chk("force_run_retry", 32'(retry_cnt), 32'd0);
    pllrst_phase("force_run");

    // One-cycle lock glitch seen on the fifth filter cycle
    tick();
    chk("glitch_filter_entry", 32'(dbg_state), ST_FILTER);
    ticks(2);
    lock = 1'b0;
    tick();
    lock = 1'b1;
    tick();
    chk("glitch_still_filter", 32'(dbg_state), ST_FILTER);
    tick();
    chk("glitch_back_wait", 32'(dbg_state), ST_WAIT);
    chk("glitch_rst_out", 32'(rst_out), 32'd7);
    filter_release("glitch");
    chk("glitch_loss", 32'(loss_cnt), 32'd0);
    chk("glitch_retry", 32'(retry_cnt), 32'd0);

    // Lock loss in S_RUN: outputs react on the third edge after LOCK falls
    lock = 1'b0;
    ticks(2);
    chk("loss_ready_e2", 32'(ready), 32'd1);
    chk("loss_rst_out_e2", 32'(rst_out), 32'd0);
    tick();
    chk_reset_values("loss_e3");
    chk("loss_cnt_1", 32'(loss_cnt), 32'd1);
    chk("loss_retry_0", 32'(retry_cnt), 32'd0);

    // Restore LOCK; a relock request inside S_PLLRST must not stretch it
    lock = 1'b1;
    tick();
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    tick();
    chk("pllrst_force_hi", 32'(pll_rst), 32'd1);
    chk("pllrst_force_state", 32'(dbg_state), ST_PLLRST);
    tick();
    chk("pllrst_force_lo", 32'(pll_rst), 32'd0);
    chk("pllrst_force_wait", 32'(dbg_state), ST_WAIT);
    filter_release("relock");
    chk("relock_loss", 32'(loss_cnt), 32'd1);

    // Relock request in S_RELEASE after RST_OUT[0] has dropped
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    pllrst_phase("rel_prep");
    ticks(9);
    chk("rel_force_pre_rst_out", 32'(rst_out), 32'd6);
    chk("rel_force_pre_state", 32'(dbg_state), ST_RELEASE);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk_reset_values("rel_force");
    chk("rel_force_loss", 32'(loss_cnt), 32'd1);
    chk("rel_force_retry", 32'(retry_cnt), 32'd0);
    pllrst_phase("rel_force");
    filter_release("rel_force");

    // Second lock loss brings LOSS_CNT to 2
    lock = 1'b0;
    ticks(3);
    chk("loss2_cnt", 32'(loss_cnt), 32'd2);
    lock = 1'b1;
    pllrst_phase("loss2");
    filter_release("loss2");
    chk("loss2_run_cnt", 32'(loss_cnt), 32'd2);

    // Mid-operation RST in S_RUN; keep LOCK low afterwards for the timeout test
    rst = 1'b1;
    lock = 1'b0;
    tick();
    rst = 1'b0;
    chk_reset_values("midrst");
    chk("midrst_loss", 32'(loss_cnt), 32'd0);
    chk("midrst_retry", 32'(retry_cnt), 32'd0);
    pllrst_phase("nolock0");

    // No lock: 50 cycles in S_WAIT, then a 4-cycle PLL_RST pulse; saturates at 15
    for (int i = 1; i <= 16; i++) begin
      ticks(49);
      chk("nolock_wait_end", 32'(pll_rst), 32'd0);
      chk("nolock_wait_retry", 32'(retry_cnt), 32'((i - 1 > 15) ? 15 : i - 1));
      tick();
      chk("nolock_pulse", 32'(pll_rst), 32'd1);
      chk("nolock_retry", 32'(retry_cnt), 32'((i > 15) ? 15 : i));
      pllrst_phase("nolock");
    end
    chk("nolock_loss", 32'(loss_cnt), 32'd0);
    chk("nolock_rst_out", 32'(rst_out), 32'd7);
    chk("nolock_ready", 32'(ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
